// File: rtl/egress_arbiter_pkg.sv
// Shared types and constants for the egress arbiter and the ingress filters
// that feed it.
package egress_arbiter_pkg;

  localparam int MAX_FRAME_BEATS = 759;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [15:0] tdata;
    logic        tlast;
    logic [7:0]  tdest;
  } axis_beat_t;

  typedef struct packed {
    logic [15:0] tdata;
    logic        tlast;
    logic        tuser;
  } out_beat_t;

endpackage

// File: rtl/egress_arbiter_if.sv
// Ingress and egress AXI-Stream bundle of one egress arbiter instance.
interface egress_arbiter_if #(
  parameter int NUM_INGRESS = 4,
  parameter int W_DEST      = 2
);
  logic [NUM_INGRESS*16-1:0]     in_tdata;
  logic [NUM_INGRESS-1:0]        in_tvalid;
  logic [NUM_INGRESS-1:0]        in_tlast;
  logic [NUM_INGRESS*W_DEST-1:0] in_tdest;
  logic [NUM_INGRESS-1:0]        in_tready;
  logic [15:0]                   out_tdata;
  logic                          out_tvalid;
  logic                          out_tlast;
  logic                          out_tuser;
  logic                          out_tready;

  modport master (
    output in_tdata, in_tvalid, in_tlast, in_tdest, out_tready,
    input  in_tready, out_tdata, out_tvalid, out_tlast, out_tuser
  );

  modport slave (
    input  in_tdata, in_tvalid, in_tlast, in_tdest, out_tready,
    output in_tready, out_tdata, out_tvalid, out_tlast, out_tuser
  );
endinterface

// File: rtl/egress_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx
);

  logic          found;
  logic          hit;
  logic [IW-1:0] j;

  // scan N positions starting at rr_ptr, keep the first hit
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    hit       = 1'b0;
    j         = '0;
    for (int k = 0; k < N; k++) begin
      j           = IW'((int'(rr_ptr) + k) % N);
      hit         = ~found & req[j];
      grant_oh[j] = hit;
      grant_idx   = hit ? j : grant_idx;
      found       = found | hit;
    end
  end

endmodule

// File: rtl/egress_arbiter.sv
// Frame-atomic round-robin merge of NUM_INGRESS tagged streams onto one
// registered egress port, with truncation of oversize frames.
module egress_arbiter
  import egress_arbiter_pkg::*;
#(
  parameter int NUM_INGRESS = 4,
  parameter int W_DEST      = 2,
  parameter int EGRESS_ID   = 0,
  parameter int MAX_BEATS   = MAX_FRAME_BEATS,
  parameter int W_CNT       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  egress_arbiter_if.slave  bus,
  output logic [W_CNT-1:0] frames_fwd,
  output logic [W_CNT-1:0] frames_trunc
);

  localparam int IDX_W = (NUM_INGRESS > 1) ? $clog2(NUM_INGRESS) : 1;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  arb_state_t             state_r, state_s;
  logic [IDX_W-1:0]       grant_r, grant_s, rr_ptr_r, rr_ptr_s, arb_idx_s;
  logic [CNT_W-1:0]       beat_cnt_r, beat_cnt_s;
  out_beat_t              out_r, out_s;
  logic                   out_valid_r, out_valid_s;
  logic [W_CNT-1:0]       fwd_r, fwd_s, trunc_r, trunc_s;
  logic [NUM_INGRESS-1:0] req_s, arb_oh_s, tready_s;
  logic [15:0]            g_data_s;
  logic                   g_valid_s, g_last_s, slot_free_s, acc_s;

  function automatic logic [W_CNT-1:0] sat_inc(input logic [W_CNT-1:0] v);
    if (&v) return v;
    else    return v + W_CNT'(1);
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_INGRESS - 1)) return '0;
    else                                return idx + IDX_W'(1);
  endfunction

  // a port requests only when its current beat is tagged for this egress
  always_comb begin
    req_s = '0;
    for (int i = 0; i < NUM_INGRESS; i++) begin
      req_s[i] = bus.in_tvalid[i] & (bus.in_tdest[W_DEST*i +: W_DEST] == W_DEST'(EGRESS_ID));
    end
  end

  rr_arbiter #(.N(NUM_INGRESS), .IW(IDX_W)) u_rr (
    .req       (req_s),
    .rr_ptr    (rr_ptr_r),
    .grant_oh  (arb_oh_s),
    .grant_idx (arb_idx_s)
  );

  // granted-port view and handshake; ready is suppressed while reset is low
  always_comb begin
    g_data_s    = bus.in_tdata[16*int'(grant_r) +: 16];
    g_valid_s   = bus.in_tvalid[grant_r];
    g_last_s    = bus.in_tlast[grant_r];
    slot_free_s = ~out_valid_r | bus.out_tready;
    tready_s    = '0;
    case (state_r)
      FWD:     tready_s[grant_r] = slot_free_s & reset;
      DRAIN:   tready_s[grant_r] = reset;
      default: tready_s          = '0;
    endcase
    acc_s = g_valid_s & tready_s[grant_r];
  end

  // next-state, output register and statistics update
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    rr_ptr_s    = rr_ptr_r;
    beat_cnt_s  = beat_cnt_r;
    out_s       = out_r;
    out_valid_s = out_valid_r & ~bus.out_tready;
    fwd_s       = fwd_r;
    trunc_s     = trunc_r;
    case (state_r)
      IDLE: begin
        if (en && (|arb_oh_s)) begin
          grant_s    = arb_idx_s;
          beat_cnt_s = '0;
          state_s    = FWD;
        end else begin
          state_s = IDLE;
        end
      end
      FWD: begin
        if (acc_s) begin
          out_valid_s = 1'b1;
          out_s.tdata = g_data_s;
          beat_cnt_s  = beat_cnt_r + CNT_W'(1);
          if (g_last_s) begin
            out_s.tlast = 1'b1;
            out_s.tuser = 1'b0;
            fwd_s       = sat_inc(fwd_r);
            rr_ptr_s    = next_idx(grant_r);
            state_s     = IDLE;
          end else if (beat_cnt_r == CNT_W'(MAX_BEATS - 1)) begin
            // cut here; the remainder of the frame is swallowed in DRAIN
            out_s.tlast = 1'b1;
            out_s.tuser = 1'b1;
            trunc_s     = sat_inc(trunc_r);
            state_s     = DRAIN;
          end else begin
            out_s.tlast = 1'b0;
            out_s.tuser = 1'b0;
          end
        end else begin
          state_s = FWD;
        end
      end
      DRAIN: begin
        if (acc_s && g_last_s) begin
          rr_ptr_s = next_idx(grant_r);
          state_s  = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      grant_r     <= '0;
      rr_ptr_r    <= '0;
      beat_cnt_r  <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      fwd_r       <= '0;
      trunc_r     <= '0;
    end else begin
      state_r     <= state_s;
      grant_r     <= grant_s;
      rr_ptr_r    <= rr_ptr_s;
      beat_cnt_r  <= beat_cnt_s;
      out_r       <= out_s;
      out_valid_r <= out_valid_s;
      fwd_r       <= fwd_s;
      trunc_r     <= trunc_s;
    end
  end

  assign bus.in_tready  = tready_s;
  assign bus.out_tdata  = out_r.tdata;
  assign bus.out_tvalid = out_valid_r;
  assign bus.out_tlast  = out_r.tlast;
  assign bus.out_tuser  = out_r.tuser;
  assign frames_fwd     = fwd_r;
  assign frames_trunc   = trunc_r;

endmodule
